// File: rtl/traffic_pkg.sv
// Shared phase encodings and default timing constants for the traffic controllers.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_G   = 3'd0,
    NS_Y   = 3'd1,
    AR_NS  = 3'd2,
    EW_G   = 3'd3,
    EW_Y   = 3'd4,
    AR_EW  = 3'd5,
    WALK_S = 3'd6
  } phase_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  localparam int unsigned TIMER_W          = 6;
  localparam int unsigned GREEN_MIN_DEF    = 10;
  localparam int unsigned GREEN_MAX_DEF    = 30;
  localparam int unsigned YELLOW_TIME_DEF  = 4;
  localparam int unsigned ALLRED_TIME_DEF  = 2;
  localparam int unsigned WALK_TIME_DEF    = 8;

endpackage

// File: rtl/tl_phase_timer.sv
// Saturating 6-bit phase timer with synchronous clear and terminal-count compare.
module tl_phase_timer
  import traffic_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic               clr,
  input  logic               en,
  input  logic [TIMER_W-1:0] term,
  output logic [TIMER_W-1:0] count,
  output logic               at_term
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && (count_q != '1))
      count_d = count_q + TIMER_W'(1);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count   = count_q;
  assign at_term = (count_q == term);

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Two-direction signal phase scheduler with demand latching, pedestrian walk and emergency preemption.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN   = GREEN_MIN_DEF,
  parameter int unsigned GREEN_MAX   = GREEN_MAX_DEF,
  parameter int unsigned YELLOW_TIME = YELLOW_TIME_DEF,
  parameter int unsigned ALLRED_TIME = ALLRED_TIME_DEF,
  parameter int unsigned WALK_TIME   = WALK_TIME_DEF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       NS_CAR,
  input  logic       EW_CAR,
  input  logic       PED_REQ,
  input  logic       EMERG_NS,
  input  logic       EMERG_EW,
  output logic       NS_RED,
  output logic       NS_YELLOW,
  output logic       NS_GREEN,
  output logic       EW_RED,
  output logic       EW_YELLOW,
  output logic       EW_GREEN,
  output logic       WALK,
  output logic       PED_ACK,
  output logic [2:0] phase,
  output logic [5:0] timer
);

  localparam logic [TIMER_W-1:0] GMIN_M1 = TIMER_W'(GREEN_MIN - 1);
  localparam logic [TIMER_W-1:0] GMAX_M1 = TIMER_W'(GREEN_MAX - 1);
  localparam logic [TIMER_W-1:0] Y_M1    = TIMER_W'(YELLOW_TIME - 1);
  localparam logic [TIMER_W-1:0] AR_M1   = TIMER_W'(ALLRED_TIME - 1);
  localparam logic [TIMER_W-1:0] WALK_M1 = TIMER_W'(WALK_TIME - 1);

  phase_t state_q, state_d;
  dir_t   nxt_dir_q, nxt_dir_d;
  logic   ns_dem_q, ns_dem_d;
  logic   ew_dem_q, ew_dem_d;
  logic   ped_pend_q, ped_pend_d;

  logic [TIMER_W-1:0] tmr, tmr_term;
  logic               tmr_at_term, tmr_clr, tmr_en;
  logic               in_green, past_min, emg_ns, emg_ew;

  tl_phase_timer u_timer (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .term    (tmr_term),
    .count   (tmr),
    .at_term (tmr_at_term)
  );

  always_comb begin
    tmr_term = GMAX_M1;
    unique case (state_q)
      NS_Y, EW_Y:   tmr_term = Y_M1;
      AR_NS, AR_EW: tmr_term = AR_M1;
      WALK_S:       tmr_term = WALK_M1;
      default:      tmr_term = GMAX_M1;
    endcase
  end

  assign in_green = (state_q == NS_G) || (state_q == EW_G);
  assign past_min = (tmr >= GMIN_M1);
  // NS preemption wins a simultaneous request.
  assign emg_ns   = EMERG_NS;
  assign emg_ew   = EMERG_EW & ~EMERG_NS;

  always_comb begin
    state_d   = state_q;
    nxt_dir_d = nxt_dir_q;
    unique case (state_q)
      NS_G: begin
        if (emg_ns)
          state_d = NS_G;
        else if (emg_ew)
          state_d = NS_Y;
        else if (past_min && (ped_pend_q || (ew_dem_q && (!NS_CAR || tmr_at_term))))
          state_d = NS_Y;
      end
      EW_G: begin
        if (emg_ew)
          state_d = EW_G;
        else if (emg_ns)
          state_d = EW_Y;
        else if (past_min && (ped_pend_q || (ns_dem_q && (!EW_CAR || tmr_at_term))))
          state_d = EW_Y;
      end
      NS_Y: if (tmr_at_term) state_d = AR_NS;
      EW_Y: if (tmr_at_term) state_d = AR_EW;
      AR_NS: begin
        if (tmr_at_term) begin
          if (emg_ns)           state_d = NS_G;
          else if (emg_ew)      state_d = EW_G;
          else if (ped_pend_q) begin
            state_d   = WALK_S;
            nxt_dir_d = DIR_EW;
          end else              state_d = EW_G;
        end
      end
      AR_EW: begin
        if (tmr_at_term) begin
          if (emg_ns)           state_d = NS_G;
          else if (emg_ew)      state_d = EW_G;
          else if (ped_pend_q) begin
            state_d   = WALK_S;
            nxt_dir_d = DIR_NS;
          end else              state_d = NS_G;
        end
      end
      WALK_S: begin
        if (emg_ns) begin
          state_d   = AR_NS;
          nxt_dir_d = DIR_NS;
        end else if (emg_ew) begin
          state_d   = AR_NS;
          nxt_dir_d = DIR_EW;
        end else if (tmr_at_term)
          state_d = (nxt_dir_q == DIR_NS) ? NS_G : EW_G;
      end
      default: state_d = NS_G;
    endcase
  end

  // Green rests at GREEN_MAX-1 once reached; any state change clears the timer.
  assign tmr_clr = (state_d != state_q);
  assign tmr_en  = !(in_green && tmr_at_term);

  always_comb begin
    ns_dem_d   = ns_dem_q;
    ew_dem_d   = ew_dem_q;
    ped_pend_d = ped_pend_q;
    if (state_d == NS_G && state_q != NS_G) ns_dem_d = 1'b0;
    else if (state_q != NS_G)               ns_dem_d = ns_dem_q | NS_CAR;
    if (state_d == EW_G && state_q != EW_G) ew_dem_d = 1'b0;
    else if (state_q != EW_G)               ew_dem_d = ew_dem_q | EW_CAR;
    if (state_d == WALK_S && state_q != WALK_S) ped_pend_d = 1'b0;
    else if (state_q != WALK_S)                 ped_pend_d = ped_pend_q | PED_REQ;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q    <= NS_G;
      nxt_dir_q  <= DIR_EW;
      ns_dem_q   <= 1'b0;
      ew_dem_q   <= 1'b0;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      nxt_dir_q  <= nxt_dir_d;
      ns_dem_q   <= ns_dem_d;
      ew_dem_q   <= ew_dem_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  always_comb begin
    NS_GREEN  = (state_q == NS_G);
    NS_YELLOW = (state_q == NS_Y);
    NS_RED    = !(NS_GREEN || NS_YELLOW);
    EW_GREEN  = (state_q == EW_G);
    EW_YELLOW = (state_q == EW_Y);
    EW_RED    = !(EW_GREEN || EW_YELLOW);
    WALK      = (state_q == WALK_S);
    PED_ACK   = (state_q == WALK_S) && (tmr == '0);
  end

  assign phase = state_q;
  assign timer = tmr;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scoreboard bench for traffic_phase_scheduler: per-cycle expected phase/timer/lamps queued by stimulus.
module tb_traffic_phase_scheduler;

  logic       CLK, RESET;
  logic       NS_CAR, EW_CAR, PED_REQ, EMERG_NS, EMERG_EW;
  logic       NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN;
  logic       WALK, PED_ACK;
  logic [2:0] phase;
  logic [5:0] timer;

  traffic_phase_scheduler #(
    .GREEN_MIN   (10),
    .GREEN_MAX   (30),
    .YELLOW_TIME (4),
    .ALLRED_TIME (2),
    .WALK_TIME   (8)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .NS_CAR    (NS_CAR),
    .EW_CAR    (EW_CAR),
    .PED_REQ   (PED_REQ),
    .EMERG_NS  (EMERG_NS),
    .EMERG_EW  (EMERG_EW),
    .NS_RED    (NS_RED),
    .NS_YELLOW (NS_YELLOW),
    .NS_GREEN  (NS_GREEN),
    .EW_RED    (EW_RED),
    .EW_YELLOW (EW_YELLOW),
    .EW_GREEN  (EW_GREEN),
    .WALK      (WALK),
    .PED_ACK   (PED_ACK),
    .phase     (phase),
    .timer     (timer)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [2:0] ph;
    logic [5:0] tm;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // {NS_R,NS_Y,NS_G,EW_R,EW_Y,EW_G,WALK} for each phase code
  function automatic logic [6:0] lamps_for(input logic [2:0] ph);
    case (ph)
      3'd0:    return 7'b001_100_0;
      3'd1:    return 7'b010_100_0;
      3'd2:    return 7'b100_100_0;
      3'd3:    return 7'b100_001_0;
      3'd4:    return 7'b100_010_0;
      3'd5:    return 7'b100_100_0;
      3'd6:    return 7'b100_100_1;
      default: return 7'b000_000_0;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      cur = exp_q.pop_front();
      check_eq($sformatf("%s.phase", cur.tag), 32'(phase), 32'(cur.ph));
      check_eq($sformatf("%s.timer", cur.tag), 32'(timer), 32'(cur.tm));
      check_eq($sformatf("%s.lamps", cur.tag),
               32'({NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN, WALK}),
               32'(lamps_for(cur.ph)));
      check_eq($sformatf("%s.ack", cur.tag), 32'(PED_ACK),
               32'((cur.ph == 3'd6) && (cur.tm == 6'd0)));
    end
  end

  task automatic tick(input string tag, input int ph, input int tm);
    exp_t e;
    e.tag = tag;
    e.ph  = 3'(ph);
    e.tm  = 6'(tm);
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    {NS_CAR, EW_CAR, PED_REQ, EMERG_NS, EMERG_EW} = '0;
    tick("rst", 0, 0);
    tick("rst", 0, 0);
    RESET = 1'b0;
  endtask

  function automatic int sat29(input int v);
    return (v < 29) ? v : 29;
  endfunction

  initial begin
    RESET = 1'b1;
    {NS_CAR, EW_CAR, PED_REQ, EMERG_NS, EMERG_EW} = '0;
    @(posedge CLK);
    #1;

    // idle: rests in NS green, timer pins at GREEN_MAX-1
    do_reset();
    for (int k = 0; k < 200; k++) tick("idle", 0, sat29(k));

    // EW demand with no NS car: exit at GREEN_MIN
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      EW_CAR = (k == 2);
      if (k < 10)      tick("ewcar", 0, k);
      else if (k < 14) tick("ewcar", 1, k - 10);
      else if (k < 16) tick("ewcar", 2, k - 14);
      else             tick("ewcar", 3, k - 16);
    end

    // NS car held: green runs to GREEN_MAX, then EW exits at GREEN_MIN on latched NS demand
    do_reset();
    NS_CAR = 1'b1;
    for (int k = 0; k <= 47; k++) begin
      EW_CAR = (k == 2);
      if (k < 30)      tick("gmax", 0, k);
      else if (k < 34) tick("gmax", 1, k - 30);
      else if (k < 36) tick("gmax", 2, k - 34);
      else if (k < 46) tick("gmax", 3, k - 36);
      else             tick("gmax", 4, k - 46);
    end

    // pedestrian walk between NS and EW greens
    do_reset();
    for (int k = 0; k <= 26; k++) begin
      EW_CAR  = (k == 1);
      PED_REQ = (k == 3);
      if (k < 10)      tick("ped", 0, k);
      else if (k < 14) tick("ped", 1, k - 10);
      else if (k < 16) tick("ped", 2, k - 14);
      else if (k < 24) tick("ped", 6, k - 16);
      else             tick("ped", 3, k - 24);
    end

    // EW preemption from NS green at timer 3, then held green despite NS demand
    do_reset();
    for (int k = 0; k <= 112; k++) begin
      EMERG_EW = (k >= 3) && (k < 110);
      NS_CAR   = (k >= 20);
      if (k < 4)        tick("emg_ew", 0, k);
      else if (k < 8)   tick("emg_ew", 1, k - 4);
      else if (k < 10)  tick("emg_ew", 2, k - 8);
      else if (k < 111) tick("emg_ew", 3, sat29(k - 10));
      else              tick("emg_ew", 4, k - 111);
    end

    // reset in the middle of a walk; pending walk must not survive
    do_reset();
    for (int k = 0; k < 20; k++) begin
      PED_REQ = (k == 1);
      if (k < 10)      tick("rst_walk", 0, k);
      else if (k < 14) tick("rst_walk", 1, k - 10);
      else if (k < 16) tick("rst_walk", 2, k - 14);
      else             tick("rst_walk", 6, k - 16);
    end
    RESET = 1'b1;
    tick("rst_walk_hit", 0, 0);
    tick("rst_walk_hit", 0, 0);
    RESET = 1'b0;
    for (int k = 0; k < 20; k++) tick("rst_walk_after", 0, k);

    // NS preemption cuts a walk short via AR_NS, then holds NS green
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      PED_REQ  = (k == 1);
      EMERG_NS = (k >= 18) && (k < 30);
      if (k < 10)      tick("emg_walk", 0, k);
      else if (k < 14) tick("emg_walk", 1, k - 10);
      else if (k < 16) tick("emg_walk", 2, k - 14);
      else if (k < 19) tick("emg_walk", 6, k - 16);
      else if (k < 21) tick("emg_walk", 2, k - 19);
      else             tick("emg_walk", 0, k - 21);
    end

    // both preemptions together: NS wins and stays green; pending walk and demand act on release
    do_reset();
    for (int k = 0; k <= 41; k++) begin
      EMERG_NS = (k < 40);
      EMERG_EW = (k < 40);
      EW_CAR   = (k == 1);
      PED_REQ  = (k == 2);
      if (k <= 40) tick("emg_both", 0, sat29(k));
      else         tick("emg_both", 1, k - 41);
    end

    @(negedge CLK);
    #1;
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
